// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM: start/done handshake,
// stall/jump/halt handling in RUN, and a saturating issued-instruction count.
module fetch_sequencer #(
    parameter int D          = 12,
    parameter int OFFW       = 8,
    parameter int START_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            jump_abs,
    input  logic            jump_rel,
    input  logic [D-1:0]    target,
    input  logic [OFFW-1:0] offset,
    input  logic            halt_req,
    output logic [D-1:0]    prog_ctr,
    output logic            fetch_valid,
    output logic            done,
    output logic [15:0]     instr_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [D-1:0]  r_pc, w_pc_nxt;
    logic [15:0]   r_cnt, w_cnt_nxt;
    logic          r_fv, r_done;
    logic [D-1:0]  w_off_ext;
    logic [15:0]   w_cnt_inc;

    assign w_off_ext = D'($signed(offset));
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                // Halt leaves PC on the halt instruction; stall drops any jump.
                if (halt_req) begin
                    w_state_nxt = S_DONE;
                end else if (!stall) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (jump_abs)      w_pc_nxt = target;
                    else if (jump_rel) w_pc_nxt = r_pc + w_off_ext;
                    else               w_pc_nxt = r_pc + 1'b1;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = D'(START_ADDR);
                    w_cnt_nxt   = 16'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_fv    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fv    <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign prog_ctr    = r_pc;
    assign instr_count = r_cnt;
    assign fetch_valid = r_fv;
    assign done        = r_done;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + randomized bench for fetch_sequencer against a simple
// behavioural model of the PC/count rules.
module tb_fetch_sequencer;

    localparam int D = 12, OFFW = 8, START_ADDR = 0;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 0, stall = 0, jump_abs = 0, jump_rel = 0, halt_req = 0;
    logic [D-1:0]    target = '0;
    logic [OFFW-1:0] offset = '0;
    logic [D-1:0]    prog_ctr;
    logic            fetch_valid, done;
    logic [15:0]     instr_count;

    int n_tests = 0, n_fail = 0;
    int m_mode = M_IDLE, m_pc = 0, m_cnt = 0;

    fetch_sequencer #(.D(D), .OFFW(OFFW), .START_ADDR(START_ADDR)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .jump_abs(jump_abs), .jump_rel(jump_rel), .target(target),
        .offset(offset), .halt_req(halt_req), .prog_ctr(prog_ctr),
        .fetch_valid(fetch_valid), .done(done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},   int'(prog_ctr),    m_pc);
        chk({tag, ".cnt"},  int'(instr_count), m_cnt);
        chk({tag, ".fv"},   int'(fetch_valid), (m_mode == M_RUN) ? 1 : 0);
        chk({tag, ".done"}, int'(done),        (m_mode == M_DONE) ? 1 : 0);
    endtask

    // Model of one clock edge using the inputs currently applied.
    task automatic model_edge();
        int o;
        if (m_mode == M_RUN) begin
            if (halt_req) m_mode = M_DONE;
            else if (!stall) begin
                if (m_cnt < 65535) m_cnt++;
                if (jump_abs) m_pc = int'(target);
                else if (jump_rel) begin
                    o = int'(offset);
                    if (o >= (1 << (OFFW - 1))) o -= (1 << OFFW);
                    m_pc = (m_pc + o + (1 << D)) % (1 << D);
                end else m_pc = (m_pc + 1) % (1 << D);
            end
        end else if (start) begin
            m_mode = M_RUN;
            m_pc   = START_ADDR;
            m_cnt  = 0;
        end
    endtask

    task automatic step(input string tag, input logic st, input logic stl,
                        input logic ja, input logic jr, input int tgt,
                        input int off, input logic hlt);
        start = st; stall = stl; jump_abs = ja; jump_rel = jr;
        target = D'(tgt); offset = OFFW'(off); halt_req = hlt;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        reset = 1'b0;

        step("start", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("free", 0, 0, 0, 0, 0, 0, 0);
        chk("free5.pc", int'(prog_ctr), 5);

        step("goto3", 0, 0, 1, 0, 3, 0, 0);
        step("stall_jmp1", 0, 1, 1, 0, 'h100, 0, 0);
        step("stall_jmp2", 0, 1, 1, 0, 'h100, 0, 0);
        chk("stall.pc", int'(prog_ctr), 3);
        step("unstall_jmp", 0, 0, 1, 0, 'h100, 0, 0);
        chk("unstall.pc", int'(prog_ctr), 'h100);
        step("abs_rel", 0, 0, 1, 1, 'h020, 5, 0);
        chk("abs_wins.pc", int'(prog_ctr), 'h020);

        step("goto10", 0, 0, 1, 0, 10, 0, 0);
        step("rel_m4", 0, 0, 0, 1, 0, 'hFC, 0);
        chk("rel_m4.pc", int'(prog_ctr), 6);
        step("goto2", 0, 0, 1, 0, 2, 0, 0);
        step("rel_m8", 0, 0, 0, 1, 0, 'hF8, 0);
        chk("rel_wrap.pc", int'(prog_ctr), 'hFFA);
        step("rel_p7f", 0, 0, 0, 1, 0, 'h7F, 0);
        step("gotoFFF", 0, 0, 1, 0, 'hFFF, 0, 0);
        step("inc_wrap", 0, 0, 0, 0, 0, 0, 0);
        chk("inc_wrap.pc", int'(prog_ctr), 0);

        step("goto7", 0, 0, 1, 0, 7, 0, 0);
        step("halt", 0, 0, 0, 0, 0, 0, 1);
        chk("halt.done", int'(done), 1);
        step("done_jabs", 0, 0, 1, 0, 'h55, 0, 0);
        step("done_jrel", 0, 0, 0, 1, 0, 3, 1);
        step("done_free", 0, 1, 0, 0, 0, 0, 0);
        chk("done_hold.pc", int'(prog_ctr), 7);
        step("restart", 1, 0, 0, 0, 0, 0, 0);
        chk("restart.cnt", int'(instr_count), 0);
        step("start_in_run", 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, (1 << D) - 1)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 19) == 0));
        end

        // Async reset between edges while running at 0x042
        step("re_start", 1, 0, 0, 0, 0, 0, 0);
        step("goto42", 0, 0, 1, 0, 'h042, 0, 0);
        #2 reset = 1'b1;
        m_mode = M_IDLE; m_pc = 0; m_cnt = 0;
        #1 check_all("async_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        step("idle_no_start", 0, 0, 1, 0, 'h123, 0, 0);
        step("idle_no_start2", 0, 0, 0, 0, 0, 0, 0);
        step("resume", 1, 0, 0, 0, 0, 0, 0);

        // Saturation: 70000 unstalled issues
        for (int i = 0; i < 70000; i++) step("sat_run", 0, 0, 0, 0, 0, 0, 0);
        chk("sat.cnt", int'(instr_count), 'hFFFF);
        step("sat_hold", 0, 0, 1, 0, 0, 0, 0);
        step("sat_hold2", 0, 0, 0, 1, 0, 'h10, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer that drives the `prog_ctr` address of the 9-bit instruction ROM. It runs a start/done handshake with the top level. Each cycle it advances, holds, or redirects the fetch address according to stall, jump and halt requests from the decoder and branch logic. It also keeps a count of issued instructions for debug and verification.

## Interface
- `D`, 12, program counter / ROM address width
- `OFFW`, 8, width of signed relative-branch offset
- `START_ADDR`, 0, address loaded on every start
- `clk`  input  1  system clock, all state on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `start`  input  1  one-cycle pulse; begins execution from `START_ADDR`
- `stall`  input  1  hold current `prog_ctr` this cycle
- `jump_abs`  input  1  load `target` into PC
- `jump_rel`  input  1  add sign-extended `offset` to PC
- `target`  input  D  absolute jump address
- `offset`  input  OFFW  two's-complement relative offset
- `halt_req`  input  1  decoder saw the halt instruction at current PC
- `prog_ctr`  output  D  fetch address to instruction ROM (registered)
- `fetch_valid`  output  1  high while in RUN: ROM output at `prog_ctr` is a live instruction
- `done`  output  1  program halted; high while in DONE
- `instr_count`  output  16  instructions issued since last start, saturating

## Operation
- FSM states: IDLE, RUN, DONE. Encoding free; no other reachable states.
- Reset (async, any state, including mid-run): state=IDLE, `prog_ctr`=0, `instr_count`=0, `done`=0, `fetch_valid`=0.
- IDLE
  - `start`=1 → RUN; `prog_ctr`←`START_ADDR`; `instr_count`←0.
  - Otherwise all outputs hold.
- RUN: one action per cycle, in strict priority order:
  1. `halt_req` → DONE; `prog_ctr` holds (points at halt instruction); count unchanged.
  2. `stall` → `prog_ctr` holds; count unchanged.
  3. `jump_abs` → `prog_ctr`←`target`; count+1.
  4. `jump_rel` → `prog_ctr`←(`prog_ctr` + sign-extended `offset`) mod 2^D; count+1.
  5. Else `prog_ctr`←(`prog_ctr`+1) mod 2^D; count+1.
- `start` is ignored in RUN.
- DONE
  - `done`=1; `prog_ctr` and `instr_count` hold.
  - All requests except `start` are ignored.
  - `start` → RUN exactly as from IDLE; `done` drops the next cycle.
- Arithmetic and widths:
  - PC arithmetic is D bits, wrapping with no flag. Increment from 2^D−1 gives 0; relative branches wrap in both directions.
  - `offset` is sign-extended from OFFW to D bits. OFFW ≤ D is required.
  - `instr_count` saturates at 16'hFFFF and never wraps.
- Simultaneous requests:
  - `jump_abs` together with `jump_rel`: absolute wins.
  - `stall` together with any jump: the jump is dropped. The requester must hold the jump until stall clears.

## Timing
- All outputs are registered. None is combinational from inputs.
- The ROM read is combinational, so the instruction at `prog_ctr` is valid in the same cycle `prog_ctr` changes.
- Start latency: `start` sampled high at edge N → state=RUN, `prog_ctr`=`START_ADDR`, `fetch_valid`=1 after edge N.
- Redirect latency: a jump or increment sampled at edge N is visible on `prog_ctr` after edge N. There is no delay slot.
- Halt: `halt_req` sampled at edge N → `done`=1 and `fetch_valid`=0 after edge N.
- `fetch_valid`=1 exactly while in RUN, including stalled cycles.

## Test plan
- Reset/start:
  - Hold `reset` 2 cycles → all outputs 0.
  - Pulse `start` → next cycle `prog_ctr`=0 and `fetch_valid`=1.
  - 5 free cycles → `prog_ctr`=5, `instr_count`=5.
- Stall and priority:
  - At PC=3, assert `stall`+`jump_abs` (`target`=12'h100) for 2 cycles → PC stays 3, count unchanged.
  - Release stall with `jump_abs` held → PC=12'h100.
  - Assert `jump_abs`+`jump_rel` together → absolute target taken.
- Relative branch and wrap:
  - At PC=10, `offset`=8'hFC (−4) → PC=6.
  - At PC=2, `offset`=8'hF8 (−8) → PC=12'hFFA.
  - At PC=12'hFFF with no request → PC=0.
- Halt/restart:
  - At PC=7 assert `halt_req` → `done`=1, `fetch_valid`=0, PC=7; further jumps ignored.
  - Pulse `start` → PC=0, `instr_count`=0, `done`=0 next cycle.
- Async reset mid-run: assert `reset` between edges while at PC=12'h042 → outputs 0 immediately, state IDLE, and `start` is required to resume.
- Count saturation: run 70000 unstalled cycles (jump back to 0 as needed) → `instr_count`=16'hFFFF and holds.
